// File: rtl/spi_sram_ctrl.sv
// SPI SRAM command sequencer: decodes instruction/address/data phases on sdi,
// drives SRAM strobes and streams read data out on sdo (byte, sequential, page modes).
module spi_sram_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int PAGE_W = 5
) (
  input  logic              sck,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              sdi,
  output logic              sdo,
  output logic              sdo_oe,
  output logic              lA,
  output logic              dA,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE, INSTR, ADDR, WDATA, RTURN, RDATA, RDSR, WRSR, DONE, ILLEGAL
  } state_t;

  localparam int SR_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(SR_W + 1);

  localparam logic [DATA_W-1:0] OP_WRSR  = DATA_W'(8'h01);
  localparam logic [DATA_W-1:0] OP_WRITE = DATA_W'(8'h02);
  localparam logic [DATA_W-1:0] OP_READ  = DATA_W'(8'h03);
  localparam logic [DATA_W-1:0] OP_RDSR  = DATA_W'(8'h05);

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [1:0]        mode;
  logic [SR_W-2:0]   in_sr;
  logic [DATA_W-1:0] sdo_sr;
  logic              is_read;
  logic              status_rd;

  logic [DATA_W-1:0] byte_in;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] status;
  logic              streaming;

  // Completed words include the bit being sampled on this edge.
  assign byte_in   = {in_sr[DATA_W-2:0], sdi};
  assign addr_in   = {in_sr[ADDR_W-2:0], sdi};
  assign status    = {mode, {(DATA_W-2){1'b0}}};
  assign streaming = (mode == 2'b01) || (mode == 2'b10);
  assign busy      = !cs_n && (state != IDLE) && (state != DONE);

  // Page mode keeps the upper address bits and wraps only inside the page.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0] m);
    logic [PAGE_W-1:0] low;
    low = a[PAGE_W-1:0] + PAGE_W'(1);
    if (m == 2'b10) return {a[ADDR_W-1:PAGE_W], low};
    return a + ADDR_W'(1);
  endfunction

  always_ff @(posedge sck) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      mode      <= 2'b00;
      in_sr     <= '0;
      sdo_sr    <= '0;
      is_read   <= 1'b0;
      status_rd <= 1'b0;
      sdo       <= 1'b0;
      sdo_oe    <= 1'b0;
      lA        <= 1'b0;
      dA        <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      lA     <= 1'b0;
      dA     <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      err    <= 1'b0;
      if (cs_n) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sdo     <= 1'b0;
        sdo_oe  <= 1'b0;
      end else begin
        in_sr <= {in_sr[SR_W-3:0], sdi};
        case (state)
          IDLE: begin
            state   <= INSTR;
            bit_cnt <= CNT_W'(1);
          end
          INSTR: begin
            if (bit_cnt == CNT_W'(DATA_W-1)) begin
              bit_cnt <= '0;
              case (byte_in)
                OP_READ:  begin state <= ADDR; is_read <= 1'b1; end
                OP_WRITE: begin state <= ADDR; is_read <= 1'b0; end
                OP_RDSR:  begin state <= RDSR; status_rd <= 1'b1; end
                OP_WRSR:  state <= WRSR;
                default:  begin state <= ILLEGAL; err <= 1'b1; end
              endcase
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          ADDR: begin
            if (bit_cnt == CNT_W'(ADDR_W-1)) begin
              bit_cnt  <= '0;
              mem_addr <= addr_in;
              lA       <= 1'b1;
              if (is_read) begin
                state     <= RTURN;
                mem_re    <= 1'b1;
                status_rd <= 1'b0;
              end else begin
                state <= WDATA;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          WDATA: begin
            // The address advances only after the write strobe has used it.
            if (mem_we && streaming) mem_addr <= next_addr(mem_addr, mode);
            if (bit_cnt == CNT_W'(DATA_W-1)) begin
              bit_cnt   <= '0;
              mem_wdata <= byte_in;
              mem_we    <= 1'b1;
              dA        <= 1'b1;
              if (!streaming) state <= DONE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          RTURN: begin
            state   <= RDATA;
            bit_cnt <= '0;
            sdo     <= mem_rdata[DATA_W-1];
            sdo_sr  <= {mem_rdata[DATA_W-2:0], 1'b0};
            sdo_oe  <= 1'b1;
          end
          RDSR: begin
            state   <= RDATA;
            bit_cnt <= '0;
            sdo     <= status[DATA_W-1];
            sdo_sr  <= {status[DATA_W-2:0], 1'b0};
            sdo_oe  <= 1'b1;
          end
          RDATA: begin
            if (bit_cnt == CNT_W'(DATA_W-1)) begin
              bit_cnt <= '0;
              if (streaming && !status_rd) begin
                sdo    <= mem_rdata[DATA_W-1];
                sdo_sr <= {mem_rdata[DATA_W-2:0], 1'b0};
              end else begin
                state  <= DONE;
                sdo    <= 1'b0;
                sdo_oe <= 1'b0;
              end
            end else begin
              sdo     <= sdo_sr[DATA_W-1];
              sdo_sr  <= {sdo_sr[DATA_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + CNT_W'(1);
              // Fetch the next byte during the bit0 cycle so the stream has no gap.
              if (bit_cnt == CNT_W'(DATA_W-2) && streaming && !status_rd) begin
                mem_addr <= next_addr(mem_addr, mode);
                mem_re   <= 1'b1;
              end
            end
          end
          WRSR: begin
            if (bit_cnt == CNT_W'(DATA_W-1)) begin
              bit_cnt <= '0;
              mode    <= byte_in[DATA_W-1 -: 2];
              state   <= DONE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Scoreboard bench for spi_sram_ctrl: expected writes/read bytes are queued when a
// transaction is driven and popped when the DUT strobes mem_we or shifts out a byte.
module tb_spi_sram_ctrl;

  logic       sck = 1'b0;
  logic       rst;
  logic       cs_n;
  logic       sdi;
  logic       sdo;
  logic       sdo_oe;
  logic       lA;
  logic       dA;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       err;

  spi_sram_ctrl #(.ADDR_W(8), .DATA_W(8), .PAGE_W(5)) dut (
    .sck(sck), .rst(rst), .cs_n(cs_n), .sdi(sdi), .sdo(sdo), .sdo_oe(sdo_oe),
    .lA(lA), .dA(dA), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  always #5 sck = ~sck;

  // Asynchronous-read SRAM array behind the controller.
  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];
  always @(posedge sck) if (mem_we) mem[mem_addr] <= mem_wdata;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int rd_bits = 0;
  logic [7:0]  rd_acc;
  logic [15:0] we_exp;
  logic [7:0]  rd_exp;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write strobe and every completed sdo byte.
  always @(negedge sck) begin
    if (!rst) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) checkOutput("unexpected_we", 32'(mem_we), 32'(0));
        else begin
          we_exp = exp_wr.pop_front();
          checkOutput("we_addr", 32'(mem_addr), 32'(we_exp[15:8]));
          checkOutput("we_data", 32'(mem_wdata), 32'(we_exp[7:0]));
        end
      end
      if (dA || mem_we) checkOutput("da_with_we", 32'(dA), 32'(mem_we));
      if (lA || dA || mem_we || mem_re) strobe_cnt++;
      if (err) err_cnt++;
      if (sdo_oe) begin
        rd_acc = {rd_acc[6:0], sdo};
        rd_bits++;
        if (rd_bits == 8) begin
          rd_bits = 0;
          if (exp_rd.size() == 0) checkOutput("unexpected_rd", 32'(sdo_oe), 32'(0));
          else begin
            rd_exp = exp_rd.pop_front();
            checkOutput("rd_byte", 32'(rd_acc), 32'(rd_exp));
          end
        end
      end else begin
        rd_bits = 0;
      end
    end
  end

  // Shifts one byte MSB-first with cs_n low; the DUT samples each bit on the next rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      @(negedge sck);
      cs_n = 1'b0;
      sdi  = b[i];
    end
  endtask

  task automatic end_txn();
    @(negedge sck);
    cs_n = 1'b1;
    sdi  = 1'b0;
    @(negedge sck);
  endtask

  task automatic write_txn(input logic [7:0] addr, input logic [7:0] d0,
                           input logic [7:0] d1, input int nbytes);
    applyStimulus(8'h02);
    applyStimulus(addr);
    applyStimulus(d0);
    if (nbytes > 1) applyStimulus(d1);
    end_txn();
  endtask

  task automatic wrsr_txn(input logic [7:0] v);
    applyStimulus(8'h01);
    applyStimulus(v);
    end_txn();
  endtask

  task automatic rdsr_txn(input logic [7:0] exp);
    exp_rd.push_back(exp);
    applyStimulus(8'h05);
    @(posedge sck); #1;
    checkOutput("rdsr_turnaround", 32'(sdo_oe), 32'(0));
    repeat (9) @(negedge sck);
    cs_n = 1'b1;
    @(negedge sck);
  endtask

  // Caller queues the expected bytes; lA/mem_re and first-bit timing are checked here.
  task automatic read_txn(input logic [7:0] addr, input int nbytes, input bit byte_mode);
    applyStimulus(8'h03);
    applyStimulus(addr);
    @(posedge sck); #1;
    checkOutput("la_pulse", 32'(lA), 32'(1));
    checkOutput("re_with_la", 32'(mem_re), 32'(1));
    checkOutput("rd_addr", 32'(mem_addr), 32'(addr));
    checkOutput("oe_in_turnaround", 32'(sdo_oe), 32'(0));
    @(posedge sck); #1;
    checkOutput("la_one_cycle", 32'(lA), 32'(0));
    checkOutput("oe_first_bit", 32'(sdo_oe), 32'(1));
    repeat (8 * nbytes) @(negedge sck);
    if (byte_mode) begin
      @(negedge sck);
      checkOutput("oe_after_byte", 32'(sdo_oe), 32'(0));
    end
    cs_n = 1'b1;
    sdi  = 1'b0;
    @(negedge sck);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst  = 1'b1;
    cs_n = 1'b1;
    sdi  = 1'b0;
    repeat (2) @(negedge sck);
    cs_n = 1'b0;
    sdi  = 1'b1;
    @(posedge sck); #1;
    checkOutput("reset_outputs", 32'({sdo, sdo_oe, lA, dA, mem_we, mem_re, busy, err}), 32'(0));
    checkOutput("reset_addr", 32'(mem_addr), 32'(0));
    checkOutput("reset_wdata", 32'(mem_wdata), 32'(0));
    @(negedge sck);
    rst  = 1'b0;
    cs_n = 1'b1;
    sdi  = 1'b0;
    @(negedge sck);

    $display("[TB] status after reset");
    rdsr_txn(8'h00);

    $display("[TB] byte write then read");
    exp_wr.push_back({8'hBD, 8'h5A});
    write_txn(8'hBD, 8'h5A, 8'h00, 1);
    exp_rd.push_back(8'h5A);
    read_txn(8'hBD, 1, 1'b1);

    $display("[TB] illegal instruction");
    s0 = strobe_cnt;
    applyStimulus(8'hFE);
    @(posedge sck); #1;
    checkOutput("err_pulse", 32'(err), 32'(1));
    @(posedge sck); #1;
    checkOutput("err_one_cycle", 32'(err), 32'(0));
    applyStimulus(8'h02);
    applyStimulus(8'h10);
    end_txn();
    checkOutput("illegal_quiet", 32'(strobe_cnt - s0), 32'(0));
    exp_wr.push_back({8'h30, 8'h77});
    write_txn(8'h30, 8'h77, 8'h00, 1);

    $display("[TB] sequential mode wrap");
    wrsr_txn(8'h40);
    rdsr_txn(8'h40);
    exp_wr.push_back({8'hFF, 8'h11});
    exp_wr.push_back({8'h00, 8'h22});
    write_txn(8'hFF, 8'h11, 8'h22, 2);
    exp_rd.push_back(8'h11);
    exp_rd.push_back(8'h22);
    read_txn(8'hFF, 2, 1'b0);

    $display("[TB] abort mid write");
    s0 = strobe_cnt;
    applyStimulus(8'h02);
    applyStimulus(8'h50);
    for (int i = 0; i < 5; i++) begin
      @(negedge sck);
      sdi = i[0];
    end
    checkOutput("busy_in_write", 32'(busy), 32'(1));
    @(negedge sck);
    cs_n = 1'b1;
    sdi  = 1'b0;
    repeat (2) @(negedge sck);
    checkOutput("abort_strobes", 32'(strobe_cnt - s0), 32'(1));
    rdsr_txn(8'h40);

    $display("[TB] page mode wrap");
    wrsr_txn(8'h80);
    rdsr_txn(8'h80);
    exp_wr.push_back({8'h3F, 8'hA1});
    exp_wr.push_back({8'h20, 8'hA2});
    write_txn(8'h3F, 8'hA1, 8'hA2, 2);
    checkOutput("page_no_spill", 32'(mem[8'h40]), 32'(0));

    $display("[TB] reset during read");
    applyStimulus(8'h03);
    applyStimulus(8'h3F);
    repeat (4) @(negedge sck);
    rst = 1'b1;
    @(posedge sck); #1;
    checkOutput("rst_mid_read", 32'({sdo, sdo_oe, lA, dA, mem_we, mem_re, busy, err}), 32'(0));
    checkOutput("rst_mid_addr", 32'(mem_addr), 32'(0));
    @(negedge sck);
    rst  = 1'b0;
    cs_n = 1'b1;
    @(negedge sck);
    rdsr_txn(8'h00);

    repeat (2) @(negedge sck);
    checkOutput("wr_queue_left", 32'(exp_wr.size()), 32'(0));
    checkOutput("rd_queue_left", 32'(exp_rd.size()), 32'(0));
    checkOutput("err_total", 32'(err_cnt), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_sram_ctrl.md
Name: spi_sram_ctrl

Overview:
Command sequencer for the SPI SRAM datapath. It decodes the serial instruction, address and data phases arriving on sdi, and drives the datapath strobes lA (latch address) and dA (latch data). It also issues single-cycle read and write strobes to the SRAM array and shifts read data out on sdo. It supports byte, sequential and page transfer modes, set through a mode register.

Parameters:
ADDR_W, 8, SRAM address width (address phase length in bits)
DATA_W, 8, data byte width (instruction and data phase length)
PAGE_W, 5, log2 of page size for page-mode wrap (32 bytes)

Ports:
sck  input  1  SPI clock; only clock, all logic on rising edge
rst  input  1  synchronous active-high reset
cs_n  input  1  chip select, active low
sdi  input  1  serial data in, MSB first, sampled on rising sck
sdo  output  1  serial data out, MSB first, registered
sdo_oe  output  1  sdo drive enable
lA  output  1  one-cycle pulse: address register valid, datapath latches address
dA  output  1  one-cycle pulse: write data byte valid, datapath latches data
mem_addr  output  ADDR_W  SRAM address
mem_wdata  output  DATA_W  SRAM write data
mem_we  output  1  one-cycle write strobe
mem_re  output  1  one-cycle read strobe; mem_rdata is valid in the same cycle (async array)
mem_rdata  input  DATA_W  SRAM read data
busy  output  1  high while cs_n low and not in IDLE or DONE
err  output  1  one-cycle pulse on illegal instruction

Behaviour:
- Reset (sync, rst=1 at rising sck) forces these values:
  - state=IDLE, bit counter=0, mode=2'b00;
  - sdo=0, sdo_oe=0, lA=0, dA=0, mem_we=0, mem_re=0, busy=0, err=0, mem_addr=0, mem_wdata=0.
  - rst has priority over all other inputs.
- cs_n=1 at any rising edge: state goes to IDLE synchronously; all strobes and sdo_oe deassert next cycle. A partial byte is discarded and no mem_we is issued for it. Mode is kept.
- States: IDLE, INSTR, ADDR, WDATA, RTURN, RDATA, RDSR, WRSR, DONE, ILLEGAL.
- IDLE -> INSTR when cs_n=0. The bit sampled on that same edge is instruction bit 7.
- INSTR: shifts 8 bits. On the 8th sample, decode:
  - 0x03 -> ADDR (read)
  - 0x02 -> ADDR (write)
  - 0x05 -> RDSR
  - 0x01 -> WRSR
  - other -> ILLEGAL, with err=1 for the next cycle.
- ADDR: shifts ADDR_W bits. On the last sample, mem_addr is loaded. In the next cycle lA=1.
  - Write: goes to WDATA.
  - Read: goes to RTURN, with mem_re=1 in the same cycle as lA.
- RTURN: one turnaround cycle; the sdo shift register loads mem_rdata at the end of it. sdo_oe=1 from the following cycle, with sdo=bit7. First data bit appears 2 cycles after the last address sample.
- RDATA: one bit per cycle, MSB first.
  - Byte mode (00/11): after bit0 -> DONE, sdo_oe=0.
  - Sequential/page mode: during the bit0 cycle, mem_addr increments and mem_re=1. The load happens at the end of that cycle, so the stream is gapless.
- WDATA: shifts DATA_W bits. On the last sample, mem_wdata is loaded. Next cycle mem_we=1 and dA=1 at the current mem_addr.
  - Byte mode -> DONE.
  - Sequential/page mode: mem_addr increments in the cycle after mem_we; stay in WDATA.
- Address increment:
  - Sequential (01): wraps 2^ADDR_W-1 -> 0.
  - Page (10): upper ADDR_W-PAGE_W bits held, low PAGE_W bits wrap (e.g. 0x3F -> 0x20).
- RDSR: shifts out {mode,6'b0} with the same 1-cycle turnaround as RTURN, then DONE.
- WRSR: shifts 8 bits; bits[7:6] go to mode on the 8th sample; then DONE. Mode takes effect on the next transaction.
- DONE / ILLEGAL: ignore sdi, no strobes, until cs_n=1.
- Simultaneous mem_we and cs_n rising: if the 8th data bit was sampled while cs_n=0, mem_we still issues on the next cycle even if cs_n=1 then.
- lA, dA, mem_we, mem_re, err are never high for more than one consecutive cycle, except mem_re in gapless streaming (once per byte).

Test Plan:
- Byte write then read: WRITE 0x02, addr 0xBD, data 0x5A; then READ 0x03, addr 0xBD -> lA pulse 1 cycle after last addr bit; mem_we/dA pulse with mem_addr=0xBD, mem_wdata=0x5A; sdo returns 0x5A MSB-first starting 2 cycles after last addr bit; sdo_oe low afterwards.
- Sequential wrap: WRSR 0x40, then WRITE at 0xFF with bytes 0x11,0x22 -> writes 0x11@0xFF, 0x22@0x00; READ 0xFF for 16 bits -> sdo=0x11 then 0x22 with no gap.
- Page wrap: WRSR 0x80, WRITE at 0x3F bytes 0xA1,0xA2 -> 0xA2 written at 0x20, not 0x40.
- Illegal instruction 0xFE -> err pulse 1 cycle; no lA/dA/mem_we/mem_re until cs_n toggles; next WRITE works normally.
- Abort: cs_n high after 5 data bits of a write -> no mem_we, state IDLE, mode unchanged. Separately, rst=1 mid-READ -> all outputs 0 and mode=00 next cycle.
- RDSR after WRSR 0x80 -> sdo shifts 0x80; after reset, RDSR -> 0x00.
